// File: rtl/wb_dma_pkg.sv
// Shared state encodings and bus constants for the Wishbone word-copy DMA master.
`timescale 1ns/1ps
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } dma_state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [3:0]  WB_SEL_OFF = 4'h0;
    localparam logic [31:0] WORD_STEP  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_dma_master.sv
// Wishbone DMA master: copies len 32-bit words from src to dst, one read then one write
// per word, with a one-cycle bus-idle gap after every termination.
`timescale 1ns/1ps
module wb_dma_master
    import wb_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          src_adr,
    input  logic [31:0]          dst_adr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    input  logic [31:0]          wb_dat_i,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = 1;

    dma_state_e           state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          hold_q, hold_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wr_next_q, wr_next_d;
    logic                 abort_q, abort_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        wr_next_d = wr_next_q;
        abort_d   = abort_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d     = word_align(src_adr);
                    dst_d     = word_align(dst_adr);
                    cnt_d     = len;
                    error_d   = 1'b0;
                    abort_d   = 1'b0;
                    wr_next_d = 1'b0;
                    busy_d    = 1'b1;
                    if (len != '0) begin
                        state_d = ST_RD;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = WB_SEL_ALL;
                        adr_d   = word_align(src_adr);
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            // Error wins over a simultaneous ack: the copy is abandoned either way.
            ST_RD, ST_WR: begin
                if (wb_err_i) begin
                    state_d = ST_FIN;
                    abort_d = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = WB_SEL_OFF;
                end else if (wb_ack_i) begin
                    state_d = ST_GAP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = WB_SEL_OFF;
                    if (state_q == ST_RD) begin
                        hold_d    = wb_dat_i;
                        wr_next_d = 1'b1;
                    end else begin
                        src_d     = src_q + WORD_STEP;
                        dst_d     = dst_q + WORD_STEP;
                        cnt_d     = cnt_q - CNT_ONE;
                        wr_next_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (wr_next_q) begin
                    state_d = ST_WR;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = WB_SEL_ALL;
                    adr_d   = dst_q;
                    dat_d   = hold_q;
                end else if (cnt_q != '0) begin
                    state_d = ST_RD;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = WB_SEL_ALL;
                    adr_d   = src_q;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                error_d = abort_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            wr_next_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= WB_SEL_OFF;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            wr_next_q <= wr_next_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_dma_master.sv
// Bench for wb_dma_master: memory-like Wishbone slave with programmable latency/error,
// expected bus traffic queued at stimulus time and compared against the slave's log.
`timescale 1ns/1ps
module tb_wb_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_adr, dst_adr;
    logic [15:0] len;
    logic        busy, done, error;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    int n_checks = 0;
    int n_pass   = 0;

    wb_dma_master #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
        .busy(busy), .done(done), .error(error),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Slave model and bus-protocol monitor
    int          lat = 1;
    int          err_wr_idx = -1;
    logic        slv_clr = 1'b0;
    int          wait_cnt, wr_idx, n_rd, n_wr, viol, unstable;
    logic        saw_term;
    logic [31:0] hold_adr;
    logic        hold_we;
    logic [31:0] rd_log [16];
    logic [31:0] wr_adr_log [16];
    logic [31:0] wr_dat_log [16];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_dat_i <= '0;
            wait_cnt <= 0;
            saw_term <= 1'b0;
        end else if (slv_clr) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wait_cnt <= 0;
            wr_idx   <= 0;
            n_rd     <= 0;
            n_wr     <= 0;
            viol     <= 0;
            unstable <= 0;
            saw_term <= 1'b0;
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            saw_term <= wb_ack_i | wb_err_i;
            if (wb_stb_o !== wb_cyc_o) viol <= viol + 1;
            if (wb_sel_o !== (wb_cyc_o ? 4'hF : 4'h0)) viol <= viol + 1;
            if (saw_term && wb_cyc_o) viol <= viol + 1;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
                if (wait_cnt != 0 && (wb_adr_o !== hold_adr || wb_we_o !== hold_we))
                    unstable <= unstable + 1;
                hold_adr <= wb_adr_o;
                hold_we  <= wb_we_o;
                if (wait_cnt >= lat - 1) begin
                    wait_cnt <= 0;
                    if (wb_we_o) begin
                        if (wr_idx == err_wr_idx) begin
                            wb_err_i <= 1'b1;
                        end else begin
                            wb_ack_i <= 1'b1;
                            if (n_wr < 16) begin
                                wr_adr_log[n_wr] <= wb_adr_o;
                                wr_dat_log[n_wr] <= wb_dat_o;
                            end
                            n_wr <= n_wr + 1;
                        end
                        wr_idx <= wr_idx + 1;
                    end else begin
                        wb_ack_i <= 1'b1;
                        wb_dat_i <= rdata(wb_adr_o);
                        if (n_rd < 16) rd_log[n_rd] <= wb_adr_o;
                        n_rd <= n_rd + 1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else if (!wb_cyc_o && wait_cnt != 0) begin
                unstable <= unstable + 1;
                wait_cnt <= 0;
            end
        end
    end

    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr_adr[$];
    logic [31:0] exp_wr_dat[$];

    task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input int nrd, input int nwr);
        exp_rd.delete(); exp_wr_adr.delete(); exp_wr_dat.delete();
        for (int i = 0; i < nrd; i++) exp_rd.push_back(s + 32'(4 * i));
        for (int i = 0; i < nwr; i++) begin
            exp_wr_adr.push_back(d + 32'(4 * i));
            exp_wr_dat.push_back(rdata(s + 32'(4 * i)));
        end
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int repulse_k, output int done_k, output int busy_cnt,
                            output int cyc_cnt, output logic err_at_done, output logic done_after);
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;
        src_adr = s; dst_adr = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_adr = $urandom; dst_adr = $urandom; len = 16'(5 + $urandom_range(0, 3));
        done_k = -1; busy_cnt = 0; cyc_cnt = 0; err_at_done = 1'bx; done_after = 1'bx;
        for (int k = 1; k <= 500; k++) begin
            if (busy) busy_cnt++;
            if (wb_cyc_o) cyc_cnt++;
            if (done) begin
                done_k = k;
                err_at_done = error;
                break;
            end
            if (k == repulse_k) begin
                start = 1'b1; len = 16'd7; src_adr = 32'h0000_0F00;
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (wb_cyc_o !== 1'b0) $display("FAIL reset_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        n_checks++; if (wb_stb_o !== 1'b0) $display("FAIL reset_stb: got %b expected 0", wb_stb_o); else n_pass++;
        n_checks++; if (wb_we_o !== 1'b0) $display("FAIL reset_we: got %b expected 0", wb_we_o); else n_pass++;
        n_checks++; if (wb_sel_o !== 4'h0) $display("FAIL reset_sel: got %h expected 0", wb_sel_o); else n_pass++;
        n_checks++; if (wb_adr_o !== 32'h0) $display("FAIL reset_adr: got %h expected 0", wb_adr_o); else n_pass++;
        n_checks++; if (wb_dat_o !== 32'h0) $display("FAIL reset_dat: got %h expected 0", wb_dat_o); else n_pass++;
        n_checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {busy, done, error}); else n_pass++;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({wb_cyc_o, busy, done, error, wb_adr_o} !== 36'h0)
            $display("FAIL idle_after_reset: got cyc=%b busy=%b done=%b err=%b adr=%h expected all 0",
                     wb_cyc_o, busy, done, error, wb_adr_o);
        else n_pass++;
    endtask

    task automatic test_basic_copy;
        int dk, bc, cc; logic ed, da;
        lat = 1; err_wr_idx = -1;
        push_expect(32'h0000_0100, 32'h7004_0000, 4, 4);
        run_copy(32'h0000_0100, 32'h7004_0000, 16'd4, 0, dk, bc, cc, ed, da);
        n_checks++; if (dk !== 26) $display("FAIL basic_done_latency: got %0d expected 26", dk); else n_pass++;
        n_checks++; if (ed !== 1'b0) $display("FAIL basic_error: got %b expected 0", ed); else n_pass++;
        n_checks++; if (da !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", da); else n_pass++;
        n_checks++; if (bc !== 25) $display("FAIL basic_busy_cycles: got %0d expected 25", bc); else n_pass++;
        n_checks++; if (cc !== 16) $display("FAIL basic_cyc_cycles: got %0d expected 16", cc); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL basic_protocol: got %0d violations expected 0", viol); else n_pass++;
        n_checks++; if (n_rd !== exp_rd.size()) $display("FAIL basic_rd_count: got %0d expected %0d", n_rd, exp_rd.size()); else n_pass++;
        for (int i = 0; i < n_rd && exp_rd.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_rd.pop_front();
            n_checks++; if (rd_log[i] !== e) $display("FAIL basic_rd_adr[%0d]: got %h expected %h", i, rd_log[i], e); else n_pass++;
        end
        n_checks++; if (n_wr !== exp_wr_adr.size()) $display("FAIL basic_wr_count: got %0d expected %0d", n_wr, exp_wr_adr.size()); else n_pass++;
        for (int i = 0; i < n_wr && exp_wr_adr.size() > 0; i++) begin
            logic [31:0] ea, ev;
            ea = exp_wr_adr.pop_front(); ev = exp_wr_dat.pop_front();
            n_checks++;
            if (wr_adr_log[i] !== ea || wr_dat_log[i] !== ev)
                $display("FAIL basic_wr[%0d]: got %h/%h expected %h/%h", i, wr_adr_log[i], wr_dat_log[i], ea, ev);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len;
        int dk, bc, cc; logic ed, da;
        run_copy(32'h0000_0040, 32'h0000_0080, 16'd0, 0, dk, bc, cc, ed, da);
        n_checks++; if (dk !== 2) $display("FAIL zero_done_latency: got %0d expected 2", dk); else n_pass++;
        n_checks++; if (bc !== 1) $display("FAIL zero_busy_cycles: got %0d expected 1", bc); else n_pass++;
        n_checks++; if (cc !== 0 || n_rd !== 0) $display("FAIL zero_no_bus: got cyc=%0d reads=%0d expected 0/0", cc, n_rd); else n_pass++;
    endtask

    task automatic test_error_abort;
        int dk, bc, cc; logic ed, da;
        lat = 1; err_wr_idx = 1;
        push_expect(32'h0000_2000, 32'h0000_3000, 2, 1);
        run_copy(32'h0000_2000, 32'h0000_3000, 16'd3, 0, dk, bc, cc, ed, da);
        err_wr_idx = -1;
        n_checks++; if (dk !== 13) $display("FAIL err_done_latency: got %0d expected 13", dk); else n_pass++;
        n_checks++; if (ed !== 1'b1) $display("FAIL err_flag: got %b expected 1", ed); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL err_cyc_drop: got %0d violations expected 0", viol); else n_pass++;
        n_checks++; if (n_rd !== exp_rd.size()) $display("FAIL err_rd_count: got %0d expected %0d", n_rd, exp_rd.size()); else n_pass++;
        n_checks++; if (n_wr !== exp_wr_adr.size()) $display("FAIL err_wr_count: got %0d expected %0d", n_wr, exp_wr_adr.size()); else n_pass++;
        if (n_wr > 0 && exp_wr_adr.size() > 0) begin
            logic [31:0] ea, ev;
            ea = exp_wr_adr.pop_front(); ev = exp_wr_dat.pop_front();
            n_checks++;
            if (wr_adr_log[0] !== ea || wr_dat_log[0] !== ev)
                $display("FAIL err_wr0: got %h/%h expected %h/%h", wr_adr_log[0], wr_dat_log[0], ea, ev);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (error !== 1'b1 || wb_cyc_o !== 1'b0) $display("FAIL err_held: got err=%b cyc=%b expected 1/0", error, wb_cyc_o); else n_pass++;
    endtask

    task automatic test_addr_wrap;
        int dk, bc, cc; logic ed, da;
        lat = 1;
        push_expect(32'hFFFF_FFF8, 32'h0000_0400, 3, 3);
        run_copy(32'hFFFF_FFF8, 32'h0000_0400, 16'd3, 0, dk, bc, cc, ed, da);
        n_checks++; if (ed !== 1'b0) $display("FAIL wrap_error_cleared: got %b expected 0", ed); else n_pass++;
        n_checks++; if (dk !== 20) $display("FAIL wrap_done_latency: got %0d expected 20", dk); else n_pass++;
        n_checks++; if (n_rd !== 3) $display("FAIL wrap_rd_count: got %0d expected 3", n_rd); else n_pass++;
        for (int i = 0; i < n_rd && exp_rd.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_rd.pop_front();
            n_checks++; if (rd_log[i] !== e) $display("FAIL wrap_rd_adr[%0d]: got %h expected %h", i, rd_log[i], e); else n_pass++;
        end
        n_checks++; if (rd_log[2] !== 32'h0000_0000) $display("FAIL wrap_to_zero: got %h expected 00000000", rd_log[2]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int dk, bc, cc, found, done_cnt; logic ed, da;
        lat = 1;
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;
        src_adr = 32'h0000_0200; dst_adr = 32'h0000_0300; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (wb_cyc_o && wb_we_o && n_wr == 1) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++; if (found !== 1) $display("FAIL rstmid_reach_wr2: got %0d expected 1", found); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, busy} !== 3'b000)
            $display("FAIL rstmid_async: got cyc=%b stb=%b busy=%b expected 000", wb_cyc_o, wb_stb_o, busy);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || wb_cyc_o || busy) done_cnt++;
            @(negedge clk);
        end
        n_checks++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_cnt); else n_pass++;
        push_expect(32'h0000_0500, 32'h0000_0600, 2, 2);
        run_copy(32'h0000_0500, 32'h0000_0600, 16'd2, 0, dk, bc, cc, ed, da);
        n_checks++; if (dk !== 14 || ed !== 1'b0) $display("FAIL rstmid_rerun: got done_k=%0d err=%b expected 14/0", dk, ed); else n_pass++;
        n_checks++; if (n_wr !== 2) $display("FAIL rstmid_rerun_writes: got %0d expected 2", n_wr); else n_pass++;
        for (int i = 0; i < n_wr && exp_wr_adr.size() > 0; i++) begin
            logic [31:0] ea, ev;
            ea = exp_wr_adr.pop_front(); ev = exp_wr_dat.pop_front();
            n_checks++;
            if (wr_adr_log[i] !== ea || wr_dat_log[i] !== ev)
                $display("FAIL rstmid_wr[%0d]: got %h/%h expected %h/%h", i, wr_adr_log[i], wr_dat_log[i], ea, ev);
            else n_pass++;
        end
    endtask

    task automatic test_slow_repulse;
        int dk, bc, cc; logic ed, da;
        lat = 3;
        push_expect(32'h0000_1000, 32'h0000_1800, 3, 3);
        run_copy(32'h0000_1000, 32'h0000_1800, 16'd3, 6, dk, bc, cc, ed, da);
        lat = 1;
        n_checks++; if (dk !== 32) $display("FAIL slow_done_latency: got %0d expected 32", dk); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL slow_stb_stable: got %0d changes expected 0", unstable); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL slow_protocol: got %0d violations expected 0", viol); else n_pass++;
        n_checks++; if (n_rd !== 3 || n_wr !== 3) $display("FAIL slow_count: got rd=%0d wr=%0d expected 3/3", n_rd, n_wr); else n_pass++;
        for (int i = 0; i < n_wr && exp_wr_adr.size() > 0; i++) begin
            logic [31:0] ea, ev;
            ea = exp_wr_adr.pop_front(); ev = exp_wr_dat.pop_front();
            n_checks++;
            if (wr_adr_log[i] !== ea || wr_dat_log[i] !== ev)
                $display("FAIL slow_wr[%0d]: got %h/%h expected %h/%h", i, wr_adr_log[i], wr_dat_log[i], ea, ev);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_error_abort();
        test_addr_wrap();
        test_reset_mid();
        test_slow_repulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
